// File: rtl/bf16_exp_sum_accum.sv
// Accumulates a stream of non-negative BF16 exp values per vector (delimited by in_last)
// and emits the BF16 sum plus beat count. Define BF16_EXP_SUM_RNE_EN for round-to-nearest-even output.
module bf16_exp_sum_accum #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_data,
   output logic [CNT_W-1:0] out_count
);

   // in_valid/ready: a beat moves on a rising edge where both are high; in_ready depends on state only.
   typedef enum logic {ACCUM, HOLD} state_t;

   state_t           state;
   logic [7:0]       acc_e;
   logic [15:0]      acc_m;
   logic             acc_inf;
   logic [CNT_W-1:0] count;

   logic [7:0]       xe, big_e, diff, nxt_e;
   logic [15:0]      xm, big_m, small_m, shifted, nxt_m;
   logic [16:0]      sum17;
   logic             nxt_inf;
   logic [CNT_W-1:0] nxt_count;
   logic [15:0]      res_data;
   logic             accept;
   logic             unused_sign;

   assign unused_sign = in_data[15];
   assign in_ready    = (state == ACCUM);
   assign accept      = in_valid && in_ready;
   assign nxt_count   = (count == {CNT_W{1'b1}}) ? count : count + {{(CNT_W-1){1'b0}}, 1'b1};

   always_comb begin
      xe      = in_data[14:7];
      xm      = {1'b1, in_data[6:0], 8'b0};
      big_e   = acc_e;
      big_m   = acc_m;
      small_m = xm;
      diff    = 8'd0;
      shifted = 16'd0;
      sum17   = 17'd0;
      nxt_e   = acc_e;
      nxt_m   = acc_m;
      nxt_inf = acc_inf;
      if (xe == 8'hFF) begin
         nxt_inf = 1'b1;
      end else if (xe == 8'd0) begin
         nxt_m = acc_m;
      end else if (acc_m == 16'd0) begin
         nxt_e = xe;
         nxt_m = xm;
      end else begin
         if (acc_e >= xe) begin
            big_e   = acc_e;
            big_m   = acc_m;
            small_m = xm;
            diff    = acc_e - xe;
         end else begin
            big_e   = xe;
            big_m   = xm;
            small_m = acc_m;
            diff    = xe - acc_e;
         end
         shifted = (diff >= 8'd16) ? 16'd0 : (small_m >> diff[3:0]);
         sum17   = {1'b0, big_m} + {1'b0, shifted};
         if (sum17[16]) begin
            nxt_m = sum17[16:1];
            nxt_e = big_e + 8'd1;
            if (big_e == 8'hFE) nxt_inf = 1'b1;
         end else begin
            nxt_m = sum17[15:0];
            nxt_e = big_e;
         end
      end
   end

`ifdef BF16_EXP_SUM_RNE_EN
   logic        rnd_inc;
   logic [14:0] rnd_val;
   // A mantissa carry ripples into the exponent; reaching 255 lands exactly on 0x7F80.
   assign rnd_inc = nxt_m[7] && ((|nxt_m[6:0]) || nxt_m[8]);
   assign rnd_val = {nxt_e, nxt_m[14:8]} + {14'd0, rnd_inc};
   always_comb begin
      if (nxt_inf)               res_data = 16'h7F80;
      else if (nxt_m == 16'd0)   res_data = 16'h0000;
      else                       res_data = {1'b0, rnd_val};
   end
`else
   always_comb begin
      if (nxt_inf)               res_data = 16'h7F80;
      else if (nxt_m == 16'd0)   res_data = 16'h0000;
      else                       res_data = {1'b0, nxt_e, nxt_m[14:8]};
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACCUM;
         acc_e     <= 8'd0;
         acc_m     <= 16'd0;
         acc_inf   <= 1'b0;
         count     <= '0;
         out_valid <= 1'b0;
         out_data  <= 16'd0;
         out_count <= '0;
      end else begin
         case (state)
            ACCUM: begin
               if (accept) begin
                  acc_e   <= nxt_e;
                  acc_m   <= nxt_m;
                  acc_inf <= nxt_inf;
                  count   <= nxt_count;
                  if (in_last) begin
                     state     <= HOLD;
                     out_valid <= 1'b1;
                     out_data  <= res_data;
                     out_count <= nxt_count;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= ACCUM;
                  out_valid <= 1'b0;
                  acc_e     <= 8'd0;
                  acc_m     <= 16'd0;
                  acc_inf   <= 1'b0;
                  count     <= '0;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_bf16_exp_sum_accum.sv
// Directed bench for bf16_exp_sum_accum: hand-computed sums, hold/stall, reset and boundary cases.
module tb_bf16_exp_sum_accum;

   localparam int CNT_W = 16;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_data;
   logic [CNT_W-1:0] out_count;

   int total = 0;
   int bad   = 0;

   bf16_exp_sum_accum #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // Called at a negedge; returns at the negedge after the beat transferred.
   task automatic send_beat(input logic [15:0] d, input logic l);
      int k;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      k = 0;
      while (!in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL send_beat_timeout got in_ready=%0b exp=1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic ack_result();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
      total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
      total++; if (out_count !== 16'd0) begin bad++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
   endtask

   task automatic test_four_ones();
      send_beat(16'h3F80, 1'b0);
      send_beat(16'h3F80, 1'b0);
      send_beat(16'h3F80, 1'b0);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL four_early_valid got=%0b exp=0", out_valid); end
      send_beat(16'h3F80, 1'b1);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL four_valid got=%0b exp=1", out_valid); end
      total++; if (out_data !== 16'h4080) begin bad++; $display("FAIL four_data got=%h exp=4080", out_data); end
      total++; if (out_count !== 16'd4) begin bad++; $display("FAIL four_count got=%0d exp=4", out_count); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL four_hold_in_ready got=%0b exp=0", in_ready); end
      ack_result();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL four_valid_drop got=%0b exp=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL four_ready_rise got=%0b exp=1", in_ready); end
   endtask

   task automatic test_small_add();
      logic [15:0] exp_d;
`ifdef BF16_EXP_SUM_RNE_EN
      exp_d = 16'h3F82;
`else
      exp_d = 16'h3F81;
`endif
      send_beat(16'h3F80, 1'b0);
      send_beat(16'h3C40, 1'b1);
      total++; if (out_data !== exp_d) begin bad++; $display("FAIL small_add_data got=%h exp=%h", out_data, exp_d); end
      total++; if (out_count !== 16'd2) begin bad++; $display("FAIL small_add_count got=%0d exp=2", out_count); end
      ack_result();
   endtask

   task automatic test_inf_sticky();
      send_beat(16'h4000, 1'b0);
      send_beat(16'h7F80, 1'b0);
      send_beat(16'h3F80, 1'b1);
      total++; if (out_data !== 16'h7F80) begin bad++; $display("FAIL inf_data got=%h exp=7f80", out_data); end
      total++; if (out_count !== 16'd3) begin bad++; $display("FAIL inf_count got=%0d exp=3", out_count); end
      ack_result();
      send_beat(16'h4040, 1'b1);
      total++; if (out_data !== 16'h4040) begin bad++; $display("FAIL inf_clear_data got=%h exp=4040", out_data); end
      total++; if (out_count !== 16'd1) begin bad++; $display("FAIL inf_clear_count got=%0d exp=1", out_count); end
      ack_result();
   endtask

   task automatic test_hold_stall();
      send_beat(16'h4000, 1'b1);
      in_valid = 1'b1;
      in_data  = 16'h3F80;
      in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || out_data !== 16'h4000 || out_count !== 16'd1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_stable cyc=%0d got v=%0b d=%h c=%0d r=%0b exp v=1 d=4000 c=1 r=0",
                     i, out_valid, out_data, out_count, in_ready);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_release_ready got=%0b exp=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_release_valid got=%0b exp=0", out_valid); end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_next_valid got=%0b exp=1", out_valid); end
      total++; if (out_data !== 16'h3F80) begin bad++; $display("FAIL hold_next_data got=%h exp=3f80", out_data); end
      total++; if (out_count !== 16'd1) begin bad++; $display("FAIL hold_next_count got=%0d exp=1", out_count); end
      ack_result();
   endtask

   task automatic test_mid_reset();
      send_beat(16'h3F80, 1'b0);
      send_beat(16'h3F80, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0b exp=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%0b exp=1", in_ready); end
      send_beat(16'h4000, 1'b1);
      total++; if (out_data !== 16'h4000) begin bad++; $display("FAIL midrst_data got=%h exp=4000", out_data); end
      total++; if (out_count !== 16'd1) begin bad++; $display("FAIL midrst_count got=%0d exp=1", out_count); end
      // A held result is dropped by reset as well.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_hold_valid got=%0b exp=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_hold_ready got=%0b exp=1", in_ready); end
   endtask

   task automatic test_denorm_sign();
      send_beat(16'h0001, 1'b0);
      send_beat(16'hBF80, 1'b1);
      total++; if (out_data !== 16'h3F80) begin bad++; $display("FAIL denorm_data got=%h exp=3f80", out_data); end
      total++; if (out_count !== 16'd2) begin bad++; $display("FAIL denorm_count got=%0d exp=2", out_count); end
      ack_result();
      send_beat(16'h0042, 1'b1);
      total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL denorm_only_data got=%h exp=0000", out_data); end
      total++; if (out_count !== 16'd1) begin bad++; $display("FAIL denorm_only_count got=%0d exp=1", out_count); end
      ack_result();
   endtask

   task automatic test_align_limits();
      // Shift of 16 drops the operand; shift of 15 leaves one bit below the guard.
      send_beat(16'h3F80, 1'b0);
      send_beat(16'h3780, 1'b0);
      send_beat(16'h3800, 1'b1);
      total++; if (out_data !== 16'h3F80) begin bad++; $display("FAIL align_data got=%h exp=3f80", out_data); end
      total++; if (out_count !== 16'd3) begin bad++; $display("FAIL align_count got=%0d exp=3", out_count); end
      ack_result();
   endtask

   task automatic test_exp_overflow();
      send_beat(16'h7F00, 1'b0);
      send_beat(16'h7F00, 1'b1);
      total++; if (out_data !== 16'h7F80) begin bad++; $display("FAIL expovf_data got=%h exp=7f80", out_data); end
      ack_result();
      send_beat(16'hFFC1, 1'b1);
      total++; if (out_data !== 16'h7F80) begin bad++; $display("FAIL nan_single_data got=%h exp=7f80", out_data); end
      ack_result();
   endtask

   task automatic test_back_to_back();
      send_beat(16'h3F80, 1'b1);
      total++; if (out_data !== 16'h3F80) begin bad++; $display("FAIL b2b_first got=%h exp=3f80", out_data); end
      ack_result();
      send_beat(16'h4000, 1'b0);
      send_beat(16'h4000, 1'b1);
      total++; if (out_data !== 16'h4080) begin bad++; $display("FAIL b2b_second got=%h exp=4080", out_data); end
      total++; if (out_count !== 16'd2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", out_count); end
      ack_result();
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 16'h0000;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_four_ones();
      test_small_add();
      test_inf_sticky();
      test_hold_stall();
      test_mid_reset();
      test_denorm_sign();
      test_align_limits();
      test_exp_overflow();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bf16_exp_sum_accum.md
Name: bf16_exp_sum_accum

Overview:
- Downstream consumer of the BF16 exp approximation stage in the softmax datapath.
- Accepts a stream of non-negative BF16 exp values, one per beat, over valid/ready.
- Accumulates each vector, delimited by `in_last`, into an extended-precision sum.
- Emits the BF16 sum and the beat count once per vector, for use by the normalisation (reciprocal/divide) stage.

Parameters:
- CNT_W, 16, width of the per-vector beat counter and of `out_count`.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  16  BF16 exp value
- in_last  in  1  final beat of current vector
- out_valid  out  1  sum result valid
- out_ready  in  1  consumer accepts result
- out_data  out  16  BF16 sum of vector
- out_count  out  CNT_W  beats in vector, saturating

Behaviour:
- Interface: one clock `clk`. Reset `rst` is synchronous, active-high.
- Reset values: `out_valid`=0, `out_data`=0, `out_count`=0. Accumulator=0 (acc_e=0, acc_m=0), count=0, inf flag=0, state=ACCUM. `in_ready`=1 on the first cycle after reset.
- Reset mid-vector: partial sum and count are discarded, and any held result is dropped.
- Handshake:
  - A beat transfers when `in_valid && in_ready`.
  - A result transfers when `out_valid && out_ready`.
  - `in_ready` = (state==ACCUM), combinational from state only.
- States:
  - ACCUM: each accepted beat updates the accumulator in the same edge and increments count.
    - Beat with `in_last`=1: the update includes that beat. Next cycle state=HOLD, `out_valid`=1, `out_data`/`out_count` registered from the final sum.
  - HOLD: `in_ready`=0, and outputs stay stable until `out_ready`.
    - On the result handshake: state goes to ACCUM, and accumulator/count/inf flag clear to zero.
    - `out_valid` falls the next cycle; `in_ready` rises the next cycle. No same-cycle bypass.
- Latency: last beat accepted at cycle N gives `out_valid` at N+1. Minimum per-vector turnaround is L beats + 1 HOLD cycle with `out_ready`=1.
- Accumulator format: acc_e[7:0] plus acc_m[15:0]. acc_m[15] is the explicit hidden bit; value is 0 iff acc_m==0.
- Input decode:
  - Sign bit is ignored.
  - xe=`in_data`[14:7]. xe==0 is treated as zero (denormals flushed), and the beat only increments count.
  - xe==255 (inf or NaN) sets the sticky inf flag.
  - Otherwise operand mantissa = {1, `in_data`[6:0], 8'b0}.
- Addition:
  - Align the smaller-exponent operand by right shift of |Δe| with truncation. A shift ≥16 contributes 0.
  - Form a 17-bit sum. On carry: shift right 1 (truncate) and increment the exponent.
  - Exponent reaching 255 sets the inf flag.
  - Accumulator zero + x gives x exactly.
- Output rounding (default): truncation, `out_data` = {0, acc_e, acc_m[14:8]}. Zero gives 0x0000. Inf flag forces 0x7F80.
- Count: increments per accepted beat, saturates at 2^CNT_W−1 with no wrap.
- Single-beat vector (`in_last` on first beat): `out_data` = input with sign cleared (denormal→0, inf/NaN→0x7F80), `out_count`=1.

Optional Feature:
- Macro: BF16_EXP_SUM_RNE_EN.
- Defined: `out_data` is rounded to nearest-even from acc_m[14:0].
  - guard = acc_m[7]; sticky = |acc_m[6:0]; lsb = acc_m[8].
  - Increment when guard && (sticky || lsb).
  - Mantissa carry increments the exponent. Exponent reaching 255 gives 0x7F80.
  - Rounding is done in the registered output path only, so the 1-cycle latency is unchanged.
- Undefined: truncation as above, and no rounding logic is present.

Test Plan:
- Four beats 0x3F80 with last on the 4th, `out_ready`=1 → `out_valid` one cycle after the 4th beat, `out_data`=0x4080, `out_count`=4. `in_ready`=0 during HOLD.
- Beats 0x3F80, 0x3C40(last) → `out_data`=0x3F81 (truncate); with BF16_EXP_SUM_RNE_EN → 0x3F82.
- Beats 0x4000, 0x7F80, 0x3F80(last) → `out_data`=0x7F80, `out_count`=3. Next vector 0x4040(last) → 0x4040 (inf flag cleared).
- Vector result held with `out_ready`=0 for 5 cycles, `in_valid`=1 throughout → outputs stable, no beats accepted. After `out_ready` pulse, `in_ready`=1 next cycle and the next vector accumulates from zero.
- `rst` asserted after 2 of 3 beats (0x3F80 each) → `out_valid`=0. Subsequent vector 0x4000(last) → `out_data`=0x4000, `out_count`=1.
- Beats 0x0001 (denormal), 0xBF80(last) → `out_data`=0x3F80 (sign ignored, denormal flushed), `out_count`=2.
